sram_write_cmd_splitter: RTL
============================

Name: sram_write_cmd_splitter

Overview:
- Upstream neighbour of the SRAM write collector in the DMA pipeline.
- Accepts one segment request per transaction: which-buffer, type (linear / broadcast / pad), global element address, element length.
- Splits it into DRAM cache-line read requests plus per-line collector commands (which, type, islast, addrofs, len).
- Each command is bounded by line end, VSIZE and the remaining length.

Parameters:
- GBW, 32, global element address width.
- CSIZE, 32, elements per DRAM cache line (power of 2).
- VSIZE, 32, elements per SRAM vector (power of 2).
- LEN_BW, 16, segment length width in elements.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  async active-low reset
- seg_rdy  in  1  segment request valid
- seg_ack  out  1  segment accepted
- i_which  in  1  target buffer (0/1)
- i_type  in  2  0=linear, 1=broadcast, 2=pad (3 treated as pad)
- i_addr  in  GBW  global element address
- i_len  in  LEN_BW  element count; 0 is illegal
- dramreq_rdy  out  1  DRAM line read request valid
- dramreq_ack  in  1  request accepted
- o_dramreq_line  out  GBW-log2(CSIZE)  line address
- cmd_rdy  out  1  collector command valid
- cmd_ack  in  1  command accepted
- o_which  out  1
- o_cmd_type  out  2
- o_cmd_islast  out  1  last command consuming the current DRAM line
- o_cmd_addrofs  out  log2(CSIZE)  element offset in line
- o_cmd_len  out  log2(VSIZE+1)  1..VSIZE

Behaviour:
- Reset (async, i_rst low): fsm=IDLE; all rdy outputs 0; data outputs 0. Reset mid-segment discards it; no partial commands after release.
- Handshake: rdy held with stable payload until ack; transfer on the rdy&&ack cycle. seg_ack asserts only in IDLE, in the same cycle as seg_rdy (combinational).
- FSM states and transitions:
  - IDLE: on seg_ack, latch which/type/addr, rem=i_len. Go to REQ for linear/broadcast, CMD for pad.
  - REQ: dramreq_rdy=1, o_dramreq_line=cur_addr>>log2(CSIZE). On ack go to CMD. Registered; one cycle min.
  - CMD: cmd_rdy=1. On cmd_ack, update state per type (below). When rem reaches 0 go to IDLE (next seg_ack earliest the following cycle).
- Linear:
  - len = min(rem, CSIZE-ofs, VSIZE); addrofs=ofs=cur_addr mod CSIZE.
  - islast=1 when ofs+len==CSIZE or len==rem.
  - On ack: cur_addr+=len, rem-=len. If islast and rem>0 go to REQ for the next line, else stay in CMD.
- Broadcast:
  - One line request for the line containing i_addr; addrofs fixed at ofs.
  - len=min(rem,VSIZE). cur_addr not advanced.
  - islast=1 only on the final chunk (len==rem).
- Pad:
  - No DRAM request; addrofs=0, len=min(rem,VSIZE), islast=0 always. o_dramreq_line unchanged.
- Rules for every command:
  - Exactly one islast=1 per DRAM request issued.
  - Command count per line is never zero.
- Arithmetic: rem is LEN_BW bits, saturating at 0 is unreachable by construction. Address increments wrap modulo 2^GBW (line wrap at top of address space is legal).
- dramreq and cmd never asserted simultaneously.

Decomposition:
- Shared package TauCfg supplies CSIZE/VSIZE/DATA widths.
- Add a package enum for command type: CMD_LINEAR=0, CMD_BCAST=1, CMD_PAD=2. The collector uses the same encoding.
- Sub-module chunk_len_min: purely combinational 3-way minimum of rem, CSIZE-ofs, VSIZE, producing len and islast. Everything else in one module.

Test Plan:
- Linear, addr=40, len=100, CSIZE=VSIZE=32:
  - Requests lines 1,2,3,4.
  - Commands (ofs,len,islast): (8,24,1),(0,32,1),(0,32,1),(0,12,1).
  - rem=0, back to IDLE.
- Linear, addr=0, len=32, CSIZE=64, VSIZE=16:
  - One request, line 0.
  - Commands (0,16,0),(16,16,1).
- Broadcast, addr=70, len=40, VSIZE=32:
  - One request, line 2.
  - Commands (6,32,0),(6,8,1).
- Pad, len=33:
  - No dramreq_rdy.
  - Commands (0,32,0),(0,1,0), type=2.
- Backpressure: hold cmd_ack/dramreq_ack low 5 cycles per transfer → payload stable, no duplicates or skips. seg_rdy held high across two segments → second ack only after first's last cmd_ack.
- Reset asserted during CMD of the second line → all rdy=0 immediately. After release, IDLE accepts a new segment with fresh counts.

Source files
------------

// File: rtl/sram_write_cmd_splitter_pkg.sv
// sram_write_cmd_splitter_pkg: sizing defaults, command-type encoding and FSM states shared with the collector
package sram_write_cmd_splitter_pkg;
   localparam int GBW_DEF    = 32;
   localparam int CSIZE_DEF  = 32;
   localparam int VSIZE_DEF  = 32;
   localparam int LEN_BW_DEF = 16;
   typedef enum logic [1:0] {
      CMD_LINEAR = 2'd0,
      CMD_BCAST  = 2'd1,
      CMD_PAD    = 2'd2
   } cmd_type_e;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_CMD  = 2'd2;
   // encoding 3 is folded onto pad so the collector never sees it
   function automatic logic [1:0] norm_type(input logic [1:0] t);
      return t == 2'd3 ? 2'(CMD_PAD) : t;
   endfunction
endpackage

// File: rtl/sram_write_cmd_splitter_chunk_len_min.sv
// chunk_len_min: command length as min(rem, CSIZE-ofs, VSIZE) plus the line/segment-end flag
module chunk_len_min #(
   parameter int CSIZE  = 32,
   parameter int VSIZE  = 32,
   parameter int LEN_BW = 16,
   localparam int OW    = $clog2(CSIZE),
   localparam int LW    = $clog2(VSIZE + 1)
) (
   input  logic [LEN_BW-1:0] rem,
   input  logic [OW-1:0]     ofs,
   input  logic              line_bound,
   output logic [LW-1:0]     len,
   output logic              islast
);
   localparam int MW = LEN_BW + $clog2(CSIZE + VSIZE) + 1;
   logic [MW-1:0] r, l, m1, m2;
   always_comb begin
      r      = MW'(rem);
      l      = line_bound ? MW'(CSIZE) - MW'(ofs) : r;
      m1     = r < l ? r : l;
      m2     = m1 < MW'(VSIZE) ? m1 : MW'(VSIZE);
      len    = LW'(m2);
      islast = (m2 == r) || (line_bound && m2 == l);
   end
endmodule

// File: rtl/sram_write_cmd_splitter.sv
// sram_write_cmd_splitter: splits segment requests into DRAM line reads and per-line collector commands
module sram_write_cmd_splitter
   import sram_write_cmd_splitter_pkg::*;
#(
   parameter int GBW    = GBW_DEF,
   parameter int CSIZE  = CSIZE_DEF,
   parameter int VSIZE  = VSIZE_DEF,
   parameter int LEN_BW = LEN_BW_DEF,
   localparam int OW    = $clog2(CSIZE),
   localparam int LW    = $clog2(VSIZE + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              seg_rdy,
   output logic              seg_ack,
   input  logic              i_which,
   input  logic [1:0]        i_type,
   input  logic [GBW-1:0]    i_addr,
   input  logic [LEN_BW-1:0] i_len,
   output logic              dramreq_rdy,
   input  logic              dramreq_ack,
   output logic [GBW-OW-1:0] o_dramreq_line,
   output logic              cmd_rdy,
   input  logic              cmd_ack,
   output logic              o_which,
   output logic [1:0]        o_cmd_type,
   output logic              o_cmd_islast,
   output logic [OW-1:0]     o_cmd_addrofs,
   output logic [LW-1:0]     o_cmd_len
);
   logic [1:0]        state;
   logic              which_q;
   logic [1:0]        type_q;
   logic [GBW-1:0]    addr_q;
   logic [LEN_BW-1:0] rem_q;
   logic [GBW-OW-1:0] line_q;
   logic [1:0]        seg_type;
   logic [LW-1:0]     len;
   logic              chunk_last;
   logic              is_lin;
   logic              is_pad;
   logic              next_line;
   logic [GBW-1:0]    next_addr;
   logic [LEN_BW-1:0] next_rem;

   chunk_len_min #(.CSIZE(CSIZE), .VSIZE(VSIZE), .LEN_BW(LEN_BW)) u_min (
      .rem        (rem_q),
      .ofs        (addr_q[OW-1:0]),
      .line_bound (is_lin),
      .len        (len),
      .islast     (chunk_last)
   );

   always_comb begin
      seg_type       = norm_type(i_type);
      is_lin         = type_q == CMD_LINEAR;
      is_pad         = type_q == CMD_PAD;
      seg_ack        = seg_rdy && i_rst && state == ST_IDLE;
      dramreq_rdy    = state == ST_REQ;
      cmd_rdy        = state == ST_CMD;
      o_dramreq_line = line_q;
      o_which        = which_q;
      o_cmd_type     = type_q;
      o_cmd_islast   = cmd_rdy && !is_pad && chunk_last;
      o_cmd_addrofs  = is_pad ? '0 : addr_q[OW-1:0];
      o_cmd_len      = len;
      // broadcast re-reads the same line slot, so only linear walks the address
      next_addr      = is_lin ? addr_q + GBW'(len) : addr_q;
      next_rem       = rem_q - LEN_BW'(len);
      next_line      = is_lin && chunk_last && next_rem != '0;
   end

   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         state   <= ST_IDLE;
         which_q <= 1'b0;
         type_q  <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         line_q  <= '0;
      end else if (state == ST_IDLE) begin
         if (seg_ack) begin
            which_q <= i_which;
            type_q  <= seg_type;
            addr_q  <= i_addr;
            rem_q   <= i_len;
            line_q  <= seg_type == CMD_PAD ? line_q : i_addr[GBW-1:OW];
            state   <= seg_type == CMD_PAD ? ST_CMD : ST_REQ;
         end
      end else if (state == ST_REQ) begin
         if (dramreq_ack)
            state <= ST_CMD;
      end else if (state == ST_CMD && cmd_ack) begin
         addr_q <= next_addr;
         rem_q  <= next_rem;
         line_q <= next_line ? next_addr[GBW-1:OW] : line_q;
         state  <= next_rem == '0 ? ST_IDLE : next_line ? ST_REQ : ST_CMD;
      end else if (state != ST_CMD) begin
         state <= ST_IDLE;
      end
endmodule
